// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream slave packet buffer.
// Holds mode constants, the drain-state encoding, width helpers and the
// reference beat layout {last, keep, data}.
package axis_pkg;

    localparam int unsigned PKT_CUT = 0;
    localparam int unsigned PKT_SAF = 1;

    localparam int unsigned AXIS_W  = 32;
    localparam int unsigned AXIS_KW = AXIS_W / 8;

    // Reference beat layout; modules re-declare it at their own WIDTH.
    typedef struct packed {
        logic               last;
        logic [AXIS_KW-1:0] keep;
        logic [AXIS_W-1:0]  data;
    } axis_beat_t;

    // Store-and-forward release state: hold for a full packet, or drain an oversize one.
    typedef enum logic {
        SAF_HOLD  = 1'b0,
        SAF_DRAIN = 1'b1
    } saf_state_e;

    // Keep lane count, never zero so narrow buses still elaborate.
    function automatic int unsigned keep_w(input int unsigned width);
        return (width / 8 > 0) ? width / 8 : 1;
    endfunction

    function automatic int unsigned beat_w(input int unsigned width);
        return width + keep_w(width) + 1;
    endfunction

endpackage

// File: rtl/axis_s_pkt_if.sv
// Bus bundle for axis_s_pkt: upstream AXIS slave side plus downstream valid/ready side.
// slave  : used by the buffer (receives s_axis_* and ready, drives tready and head beat).
// master : used by the surrounding logic / bench (the opposite directions).
interface axis_s_pkt_if
    import axis_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned KW = keep_w(WIDTH);

    logic [WIDTH-1:0] s_axis_tdata;
    logic [KW-1:0]    s_axis_tkeep;
    logic             s_axis_tlast;
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic             ready;
    logic             valid_out;
    logic [WIDTH-1:0] data_out;
    logic [KW-1:0]    keep_out;
    logic             last_out;

    modport slave (
        input  s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid, ready,
        output s_axis_tready, valid_out, data_out, keep_out, last_out
    );

    modport master (
        output s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tvalid, ready,
        input  s_axis_tready, valid_out, data_out, keep_out, last_out
    );

endinterface

// File: rtl/axis_s_ram.sv
// Beat storage: DEPTH x BW register array, async reset to zero,
// one synchronous write port and one combinational read port.
// Ports: clk, rst_n, we/waddr/wdata (write), raddr/rdata (read).
module axis_s_ram #(
    parameter  int unsigned DEPTH = 8,
    parameter  int unsigned BW    = 37,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [BW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [BW-1:0] rdata
);

    logic [BW-1:0] mem [DEPTH];

    // Cleared on reset so the head read never shows stale or unknown content.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_s_pkt.sv
// AXI-Stream slave ingress buffer with first-word-fall-through head output,
// optional tkeep carriage and optional store-and-forward packet release.
// Ports: clk, rst_n; bus (axis_s_pkt_if.slave: s_axis_* in, s_axis_tready out,
// ready in, valid_out/data_out/keep_out/last_out out); count (beats stored);
// pkt_count (complete packets stored).
module axis_s_pkt
    import axis_pkg::*;
#(
    parameter  int unsigned WIDTH    = 32,
    parameter  int unsigned DEPTH    = 8,
    parameter  int unsigned KEEP_EN  = 0,
    parameter  int unsigned PKT_MODE = 0,
    localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    axis_s_pkt_if.slave     bus,
    output logic [CW-1:0]   count,
    output logic [CW-1:0]   pkt_count
);

    localparam int unsigned KW = keep_w(WIDTH);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned BW = beat_w(WIDTH);

    typedef struct packed {
        logic             last;
        logic [KW-1:0]    keep;
        logic [WIDTH-1:0] data;
    } beat_t;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    beat_t         wr_beat;
    beat_t         rd_beat;
    saf_state_e    state_q;
    saf_state_e    state_d;
    logic          draining;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign draining = (state_q == SAF_DRAIN);

    // tready depends on registered count only, so ready never reaches it combinationally.
    assign bus.s_axis_tready = !full;
    assign push = bus.s_axis_tvalid & !full;
    assign pop  = bus.valid_out & bus.ready;

    // Cut-through shows any stored beat; store-and-forward waits for a whole packet,
    // a full buffer, or an oversize packet that has already started draining.
    assign bus.valid_out = !empty & ((PKT_MODE == PKT_CUT) | (pkt_count != '0) | full | draining);

    // Incoming beat; keep lanes forced on when keep carriage is disabled.
    always_comb begin
        wr_beat      = '0;
        wr_beat.data = bus.s_axis_tdata;
        wr_beat.keep = (KEEP_EN != 0) ? bus.s_axis_tkeep : {KW{1'b1}};
        wr_beat.last = bus.s_axis_tlast;
    end

    axis_s_ram #(
        .DEPTH (DEPTH),
        .BW    (BW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_beat),
        .raddr (rd_ptr),
        .rdata (rd_beat)
    );

    assign bus.data_out = rd_beat.data;
    assign bus.keep_out = (KEEP_EN != 0) ? rd_beat.keep : {KW{1'b1}};
    assign bus.last_out = rd_beat.last;

    // Pointers and occupancy counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pkt_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count     <= count + CW'(push) - CW'(pop);
            pkt_count <= pkt_count + CW'(push & bus.s_axis_tlast) - CW'(pop & bus.last_out);
        end
    end

    // Drain state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SAF_HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    // Enter drain when a beat leaves with no complete packet stored (full-buffer release);
    // leave drain once that packet's last beat has gone.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SAF_HOLD: begin
                if (pop && (pkt_count == '0)) begin
                    state_d = SAF_DRAIN;
                end
            end
            SAF_DRAIN: begin
                if (pop && bus.last_out) begin
                    state_d = SAF_HOLD;
                end
            end
            default: state_d = SAF_HOLD;
        endcase
    end

endmodule

// File: tb/tb_axis_s_pkt.sv
// Bench for axis_s_pkt: a cut-through/keep instance (ct) and a store-and-forward
// instance without keep (sf) share one stimulus stream; a queue model checks both every cycle.
module tb_axis_s_pkt;
    import axis_pkg::*;

    localparam int W  = 32;
    localparam int D  = 8;
    localparam int KW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0]  tdata;
    logic [KW-1:0] tkeep;
    logic          tlast;
    logic          tvalid;
    logic          ready;
    logic [3:0]    cnt_ct, pc_ct, cnt_sf, pc_sf;

    axis_s_pkt_if #(.WIDTH(W)) if_ct ();
    axis_s_pkt_if #(.WIDTH(W)) if_sf ();

    assign if_ct.s_axis_tdata  = tdata;
    assign if_ct.s_axis_tkeep  = tkeep;
    assign if_ct.s_axis_tlast  = tlast;
    assign if_ct.s_axis_tvalid = tvalid;
    assign if_ct.ready         = ready;
    assign if_sf.s_axis_tdata  = tdata;
    assign if_sf.s_axis_tkeep  = tkeep;
    assign if_sf.s_axis_tlast  = tlast;
    assign if_sf.s_axis_tvalid = tvalid;
    assign if_sf.ready         = ready;

    axis_s_pkt #(.WIDTH(W), .DEPTH(D), .KEEP_EN(1), .PKT_MODE(0)) dut_ct (
        .clk(clk), .rst_n(rst_n), .bus(if_ct.slave), .count(cnt_ct), .pkt_count(pc_ct));
    axis_s_pkt #(.WIDTH(W), .DEPTH(D), .KEEP_EN(0), .PKT_MODE(1)) dut_sf (
        .clk(clk), .rst_n(rst_n), .bus(if_sf.slave), .count(cnt_sf), .pkt_count(pc_sf));

    logic          v_out [2];
    logic          t_rdy [2];
    logic          l_out [2];
    logic [W-1:0]  d_out [2];
    logic [KW-1:0] k_out [2];
    logic [3:0]    c_out [2];
    logic [3:0]    p_out [2];
    assign v_out[0] = if_ct.valid_out;     assign v_out[1] = if_sf.valid_out;
    assign t_rdy[0] = if_ct.s_axis_tready; assign t_rdy[1] = if_sf.s_axis_tready;
    assign l_out[0] = if_ct.last_out;      assign l_out[1] = if_sf.last_out;
    assign d_out[0] = if_ct.data_out;      assign d_out[1] = if_sf.data_out;
    assign k_out[0] = if_ct.keep_out;      assign k_out[1] = if_sf.keep_out;
    assign c_out[0] = cnt_ct;              assign c_out[1] = cnt_sf;
    assign p_out[0] = pc_ct;               assign p_out[1] = pc_sf;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: each instance is an ordered list of {last, keep, data} beats.
    logic [36:0] q0[$];
    logic [36:0] q1[$];
    bit          started [2];   // head packet has already had a non-last beat leave

    function automatic int qn(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [36:0] qh(input int k);
        if (qn(k) == 0) return '0;
        return (k == 0) ? q0[0] : q1[0];
    endfunction

    function automatic int qp(input int k);
        int c = 0;
        if (k == 0) begin
            foreach (q0[i]) c += int'(q0[i][36]);
        end else begin
            foreach (q1[i]) c += int'(q1[i][36]);
        end
        return c;
    endfunction

    // ct shows anything stored; sf shows beats once a whole packet is in, the
    // buffer is full, or the head packet is already partly gone.
    function automatic bit m_valid(input int k);
        if (qn(k) == 0) return 1'b0;
        if (k == 0) return 1'b1;
        return (qp(k) > 0) || (qn(k) == D) || started[k];
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        bit          ps [2];
        bit          pp [2];
        logic [36:0] b;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            started[0] = 1'b0;
            started[1] = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                ps[k] = tvalid && (qn(k) < D);
                pp[k] = m_valid(k) && ready;
            end
            for (int k = 0; k < 2; k++) begin
                if (pp[k]) begin
                    b = (k == 0) ? q0.pop_front() : q1.pop_front();
                    started[k] = !b[36];
                end
                if (ps[k]) begin
                    if (k == 0) q0.push_back({tlast, tkeep, tdata});
                    else        q1.push_back({tlast, tkeep, tdata});
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        bit          ev;
        logic [36:0] h;
        string       nm;
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                nm = (k == 0) ? "ct" : "sf";
                ev = m_valid(k);
                h  = qh(k);
                chk({nm, ".valid_out"},  64'(v_out[k]), 64'(ev));
                chk({nm, ".tready"},     64'(t_rdy[k]), 64'(qn(k) < D));
                chk({nm, ".count"},      64'(c_out[k]), 64'(qn(k)));
                chk({nm, ".pkt_count"},  64'(p_out[k]), 64'(qp(k)));
                if (ev) begin
                    chk({nm, ".data_out"}, 64'(d_out[k]), 64'(h[31:0]));
                    chk({nm, ".last_out"}, 64'(l_out[k]), 64'(h[36]));
                    chk({nm, ".keep_out"}, 64'(k_out[k]), (k == 0) ? 64'(h[35:32]) : 64'(4'hF));
                end
            end
        end
    end

    bit          log_sf = 1'b0;
    logic [31:0] sf_log[$];

    task automatic tick();
        @(negedge clk);
        #1;
        if (log_sf && v_out[1] && ready) sf_log.push_back(d_out[1]);
    endtask

    task automatic beat(input logic [31:0] d, input logic [3:0] kp, input logic l);
        tvalid = 1'b1;
        tdata  = d;
        tkeep  = kp;
        tlast  = l;
    endtask

    task automatic idle();
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    // Present a beat and hold it until instance sel accepts it (bounded).
    task automatic push_hold(input int sel, input logic [31:0] d, input logic [3:0] kp, input logic l);
        bit acc;
        bit done;
        done = 1'b0;
        beat(d, kp, l);
        for (int c = 0; c < 32; c++) begin
            acc = t_rdy[sel];
            tick();
            if (acc) begin
                done = 1'b1;
                break;
            end
        end
        chk("push_accept", 64'(done), 64'(1));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".ct.valid"}, 64'(v_out[0]), 64'(0));
        chk({tag, ".sf.valid"}, 64'(v_out[1]), 64'(0));
        chk({tag, ".ct.tready"}, 64'(t_rdy[0]), 64'(1));
        chk({tag, ".sf.tready"}, 64'(t_rdy[1]), 64'(1));
        chk({tag, ".ct.data"}, 64'(d_out[0]), 64'(0));
        chk({tag, ".sf.data"}, 64'(d_out[1]), 64'(0));
        chk({tag, ".ct.keep"}, 64'(k_out[0]), 64'(0));
        chk({tag, ".sf.keep"}, 64'(k_out[1]), 64'(4'hF));
        chk({tag, ".ct.last"}, 64'(l_out[0]), 64'(0));
        chk({tag, ".ct.count"}, 64'(c_out[0]), 64'(0));
        chk({tag, ".sf.pkt"}, 64'(p_out[1]), 64'(0));
    endtask

    initial begin
        tvalid = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0; ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_reset_vals("rst0");
        rst_n = 1'b1;
        tick();
        chk("post_rst.tready", 64'(t_rdy[0]), 64'(1));
        chk("post_rst.count",  64'(c_out[0]), 64'(0));

        // Cut-through with keep: 0x11, 0x22, 0x33(last, keep 0x3).
        ready = 1'b1;
        beat(32'h11, 4'hF, 1'b0); tick();
        chk("ct1.data", 64'(d_out[0]), 64'h11);
        chk("ct1.last", 64'(l_out[0]), 64'(0));
        beat(32'h22, 4'hF, 1'b0); tick();
        chk("ct2.data", 64'(d_out[0]), 64'h22);
        chk("ct2.keep", 64'(k_out[0]), 64'hF);
        beat(32'h33, 4'h3, 1'b1); tick();
        chk("ct3.data", 64'(d_out[0]), 64'h33);
        chk("ct3.keep", 64'(k_out[0]), 64'h3);
        chk("ct3.last", 64'(l_out[0]), 64'(1));
        chk("sf3.valid", 64'(v_out[1]), 64'(1));
        chk("sf3.pkt",   64'(p_out[1]), 64'(1));
        chk("sf3.data",  64'(d_out[1]), 64'h11);
        chk("sf3.keep",  64'(k_out[1]), 64'hF);
        idle(); tick();
        chk("ct4.valid", 64'(v_out[0]), 64'(0));
        chk("sf4.data",  64'(d_out[1]), 64'h22);
        repeat (3) tick();

        // Backpressure: fill to DEPTH, hold the ninth, release one slot.
        ready = 1'b0;
        for (int i = 0; i < 8; i++) push_hold(0, 32'h100 + 32'(i), 4'hF, 1'b0);
        chk("full.ct.count",  64'(c_out[0]), 64'(8));
        chk("full.ct.tready", 64'(t_rdy[0]), 64'(0));
        chk("full.sf.valid",  64'(v_out[1]), 64'(1));
        beat(32'h108, 4'hF, 1'b1);
        repeat (2) tick();
        chk("hold.ct.count", 64'(c_out[0]), 64'(8));
        ready = 1'b1; tick();
        chk("pop1.ct.count",  64'(c_out[0]), 64'(7));
        chk("pop1.ct.tready", 64'(t_rdy[0]), 64'(1));
        chk("pop1.ct.data",   64'(d_out[0]), 64'h101);
        ready = 1'b0; tick();
        chk("ninth.ct.count",  64'(c_out[0]), 64'(8));
        chk("ninth.ct.tready", 64'(t_rdy[0]), 64'(0));
        idle(); ready = 1'b1; tick();
        chk("drain.ct.data", 64'(d_out[0]), 64'h102);
        repeat (10) tick();

        // Store-and-forward: 4-beat packet at one beat per two cycles.
        for (int i = 0; i < 4; i++) begin
            beat(32'hA0 + 32'(i), 4'hF, 1'(i == 3)); tick();
            if (i < 3) begin
                chk("saf.valid_lo", 64'(v_out[1]), 64'(0));
                chk("saf.pkt0",     64'(p_out[1]), 64'(0));
            end else begin
                chk("saf.valid_hi", 64'(v_out[1]), 64'(1));
                chk("saf.pkt1",     64'(p_out[1]), 64'(1));
                chk("saf.head",     64'(d_out[1]), 64'hA0);
            end
            idle(); tick();
            if (i < 3) chk("saf.gap_lo", 64'(v_out[1]), 64'(0));
        end
        repeat (4) tick();
        chk("saf.pkt_end",   64'(p_out[1]), 64'(0));
        chk("saf.count_end", 64'(c_out[1]), 64'(0));

        // Oversize packet on sf: 12 beats, released once full, drained in order.
        sf_log.delete();
        log_sf = 1'b1;
        for (int i = 0; i < 12; i++) begin
            push_hold(1, 32'hC0 + 32'(i), 4'hF, 1'(i == 11));
            if (i < 7) chk("ovr.valid_lo", 64'(v_out[1]), 64'(0));
            if (i == 7) begin
                chk("ovr.full_count", 64'(c_out[1]), 64'(8));
                chk("ovr.full_valid", 64'(v_out[1]), 64'(1));
            end
        end
        idle();
        repeat (12) tick();
        log_sf = 1'b0;
        chk("ovr.n_out", 64'(sf_log.size()), 64'(12));
        for (int i = 0; i < 12; i++) begin
            if (i < sf_log.size()) chk("ovr.order", 64'(sf_log[i]), 64'(32'hC0 + 32'(i)));
        end
        // Drain must have ended: a fresh partial packet stays hidden.
        beat(32'hD0, 4'hF, 1'b0); tick();
        idle(); tick();
        chk("post_ovr.valid", 64'(v_out[1]), 64'(0));
        chk("post_ovr.count", 64'(c_out[1]), 64'(1));
        beat(32'hD1, 4'hF, 1'b1); tick();
        chk("post_ovr.rel",  64'(v_out[1]), 64'(1));
        chk("post_ovr.head", 64'(d_out[1]), 64'hD0);
        idle();
        repeat (4) tick();

        // Reset mid-packet: content discarded at once.
        ready = 1'b0;
        for (int i = 0; i < 3; i++) push_hold(0, 32'hE0 + 32'(i), 4'h7, 1'b0);
        beat(32'hE3, 4'h7, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        idle(); tick();
        rst_n = 1'b1;
        tick();
        chk("rel.count",  64'(c_out[1]), 64'(0));
        chk("rel.tready", 64'(t_rdy[1]), 64'(1));
        beat(32'hF0, 4'hF, 1'b1); tick();
        chk("rel.ct.data", 64'(d_out[0]), 64'hF0);
        chk("rel.sf.data", 64'(d_out[1]), 64'hF0);
        idle(); ready = 1'b1;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by %0t, required finish", $time);
        $fatal(1);
    end

endmodule
